// File: rtl/sumador_ascii_ctrl_if.sv
// sumador_ascii_ctrl_if
//   Bundles every non-clock/reset signal of the ASCII adder sequencer.
//   Character stream : char_valid, char_data[6:0], char_ready
//   Control          : clear
//   Adder side       : add_a[6:0], add_b[6:0], add_cin -> adder; add_sum[7:0], add_cout <- adder
//   Result stream    : res_valid, res_sum[7:0], res_cout, res_ready
//   Status           : err
//   Modport slave  = the controller; modport master = its environment.
interface sumador_ascii_ctrl_if;
    logic       char_valid;
    logic [6:0] char_data;
    logic       char_ready;
    logic       clear;
    logic [6:0] add_a;
    logic [6:0] add_b;
    logic       add_cin;
    logic [7:0] add_sum;
    logic       add_cout;
    logic       res_valid;
    logic [7:0] res_sum;
    logic       res_cout;
    logic       res_ready;
    logic       err;

    modport slave (
        input  char_valid, char_data, clear, add_sum, add_cout, res_ready,
        output char_ready, add_a, add_b, add_cin, res_valid, res_sum, res_cout, err
    );

    modport master (
        output char_valid, char_data, clear, add_sum, add_cout, res_ready,
        input  char_ready, add_a, add_b, add_cin, res_valid, res_sum, res_cout, err
    );
endinterface

// File: rtl/sumador_ascii_ctrl.sv
// sumador_ascii_ctrl
//   Sequencer in front of the 8-bit ASCII adder. Takes operand A then operand B
//   from one character stream, holds them on the adder inputs, waits
//   SETTLE_CYCLES clocks, registers sum/carry and offers them on a valid/ready
//   result handshake.
// Ports
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : sumador_ascii_ctrl_if.slave (character, adder, result, clear, err)
// Parameters
//   CIN_VAL       : constant carry-in driven to the adder
//   SETTLE_CYCLES : clocks from operand B capture to result sampling (1..15)
// Optional feature
//   SUMADOR_DIGIT_CHECK_EN : when defined, characters outside '0'..'9' are
//   handshaken but discarded and flagged with a one-cycle err pulse.
module sumador_ascii_ctrl #(
    parameter logic        CIN_VAL       = 1'b0,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sumador_ascii_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {S_A, S_B, S_ADD, S_OUT} state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [6:0] op_a_q, op_a_d;
    logic [6:0] op_b_q, op_b_d;
    logic [3:0] cnt_q, cnt_d;
    logic       res_valid_q, res_valid_d;
    logic [7:0] res_sum_q, res_sum_d;
    logic       res_cout_q, res_cout_d;
    logic       err_q, err_d;
    logic       clr_q, clr_d;     // set for the cycle right after a clear
    logic       char_ready;
    logic       xfer;
    logic       char_ok;

`ifdef SUMADOR_DIGIT_CHECK_EN
    assign char_ok = (bus.char_data >= 7'h30) && (bus.char_data <= 7'h39);
`else
    assign char_ok = 1'b1;
`endif

    // Input side is closed in the cycle following a clear so a character
    // presented alongside the abort cannot slip in as operand A.
    assign char_ready = ((state_q == S_A) || (state_q == S_B)) && !clr_q;
    assign xfer       = bus.char_valid && char_ready;

    assign bus.char_ready = char_ready;
    assign bus.add_a      = op_a_q;
    assign bus.add_b      = op_b_q;
    assign bus.add_cin    = CIN_VAL;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_sum    = res_sum_q;
    assign bus.res_cout   = res_cout_q;
    assign bus.err        = err_q;

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        cnt_d       = cnt_q;
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_cout_d  = res_cout_q;
        err_d       = 1'b0;
        clr_d       = 1'b0;

        if (bus.clear) begin
            // Abort wins over everything, including a pending result.
            state_d     = S_A;
            op_a_d      = '0;
            op_b_d      = '0;
            cnt_d       = '0;
            res_valid_d = 1'b0;
            clr_d       = 1'b1;
        end else begin
            case (state_q)
                S_A: begin
                    if (xfer) begin
                        if (char_ok) begin
                            op_a_d  = bus.char_data;
                            state_d = S_B;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_B: begin
                    if (xfer) begin
                        if (char_ok) begin
                            op_b_d  = bus.char_data;
                            cnt_d   = CNT_INIT;
                            state_d = S_ADD;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_ADD: begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        res_sum_d   = bus.add_sum;
                        res_cout_d  = bus.add_cout;
                        res_valid_d = 1'b1;
                        state_d     = S_OUT;
                    end
                end
                S_OUT: begin
                    // res_valid is always high here, so ready alone completes it.
                    if (bus.res_ready) begin
                        res_valid_d = 1'b0;
                        state_d     = S_A;
                    end
                end
                default: state_d = S_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_A;
            op_a_q      <= '0;
            op_b_q      <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_cout_q  <= 1'b0;
            err_q       <= 1'b0;
            clr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_cout_q  <= res_cout_d;
            err_q       <= err_d;
            clr_q       <= clr_d;
        end
    end

endmodule
